// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types: branch outcome plus BTB entry, state and counter constants
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        BTB_CLEAR = 1'b0,
        BTB_READY = 1'b1
    } BtbState;

    localparam logic [1:0] BTB_CTR_WEAK_TAKEN   = 2'b10;
    localparam logic [1:0] BTB_CTR_STRONG_TAKEN = 2'b11;

    // Tag is held zero-extended to full address width so the type is
    // independent of the entry count.
    typedef struct packed {
        logic                   valid;
        logic [`ADDR_WIDTH-1:0] tag;
        logic [`ADDR_WIDTH-1:0] target;
        logic [1:0]             ctr;
    } BtbEntry;

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup, EX update, flush and statistics bundle for the BTB
interface branch_target_buffer_if #(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int STAT_W = 32
);
    import mips_core_pkg::*;

    logic              i_lookup_valid;
    logic [ADDR_W-1:0] i_lookup_pc;
    logic              o_hit;
    logic [ADDR_W-1:0] o_target;
    BranchOutcome      o_prediction;

    logic              i_upd_valid;
    logic [ADDR_W-1:0] i_upd_pc;
    logic [ADDR_W-1:0] i_upd_target;
    BranchOutcome      i_upd_outcome;
    logic              i_upd_is_jump;

    logic              i_flush_req;
    logic              o_busy;
    logic [STAT_W-1:0] o_lookup_count;
    logic [STAT_W-1:0] o_hit_count;

    modport master (
        output i_lookup_valid, i_lookup_pc,
        output i_upd_valid, i_upd_pc, i_upd_target, i_upd_outcome, i_upd_is_jump,
        output i_flush_req,
        input  o_hit, o_target, o_prediction, o_busy, o_lookup_count, o_hit_count
    );

    modport slave (
        input  i_lookup_valid, i_lookup_pc,
        input  i_upd_valid, i_upd_pc, i_upd_target, i_upd_outcome, i_upd_is_jump,
        input  i_flush_req,
        output o_hit, o_target, o_prediction, o_busy, o_lookup_count, o_hit_count
    );
endinterface

// File: rtl/branch_target_buffer_sat_counter.sv
// rtl/branch_target_buffer_sat_counter.sv - next 2-bit direction counter for a BTB write
module btb_sat_counter
    import mips_core_pkg::*;
(
    input  logic         hit,
    input  logic         is_jump,
    input  BranchOutcome outcome,
    input  logic [1:0]   ctr,
    output logic [1:0]   ctr_next
);

    // Jumps pin the counter strong-taken, fresh allocations start weak-taken,
    // hits on conditional branches move one step and saturate.
    always_comb begin
        ctr_next = ctr;
        if (is_jump) begin
            ctr_next = BTB_CTR_STRONG_TAKEN;
        end else if (!hit) begin
            ctr_next = BTB_CTR_WEAK_TAKEN;
        end else if (outcome == TAKEN) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'b01;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped tagged BTB with invalidate walk and hit statistics
module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = `ADDR_WIDTH,
    parameter int STAT_W  = 32
) (
    input logic clk,
    input logic rst,
    branch_target_buffer_if.slave bus
);

    localparam int IW = $clog2(ENTRIES);

    BtbState             state_q, state_d;
    logic [IW-1:0]       clr_idx_q, clr_idx_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [STAT_W-1:0]   lookup_cnt_q, lookup_cnt_d;
    logic [STAT_W-1:0]   hit_cnt_q, hit_cnt_d;

    // Payload storage carries no reset so it can map onto RAM.
    logic [ADDR_W-1:0]   tag_mem    [ENTRIES];
    logic [ADDR_W-1:0]   target_mem [ENTRIES];
    logic [1:0]          ctr_mem    [ENTRIES];

    logic                busy;
    logic [IW-1:0]       lk_idx, up_idx;
    logic [ADDR_W-1:0]   lk_tag, up_tag;
    BtbEntry             rd_entry;
    BtbEntry             wr_entry;
    logic                lk_hit, up_hit, upd_accept;
    logic                wr_en, wr_target_en;
    logic [1:0]          ctr_next;
    logic                pc_low_unused;

    assign busy   = (state_q == BTB_CLEAR);
    assign lk_idx = bus.i_lookup_pc[IW+1:2];
    assign up_idx = bus.i_upd_pc[IW+1:2];
    assign lk_tag = ADDR_W'(bus.i_lookup_pc[ADDR_W-1:IW+2]);
    assign up_tag = ADDR_W'(bus.i_upd_pc[ADDR_W-1:IW+2]);
    assign pc_low_unused = ^{bus.i_lookup_pc[1:0], bus.i_upd_pc[1:0]};

    // Lookup port: zero-latency read of the indexed entry, no bypass from the update port.
    always_comb begin
        rd_entry.valid  = valid_q[lk_idx];
        rd_entry.tag    = tag_mem[lk_idx];
        rd_entry.target = target_mem[lk_idx];
        rd_entry.ctr    = ctr_mem[lk_idx];
        lk_hit = bus.i_lookup_valid & ~busy & rd_entry.valid & (rd_entry.tag == lk_tag);
    end

    assign bus.o_hit          = lk_hit;
    assign bus.o_target       = lk_hit ? rd_entry.target : '0;
    assign bus.o_prediction   = (lk_hit && rd_entry.ctr[1]) ? TAKEN : NOT_TAKEN;
    assign bus.o_busy         = busy;
    assign bus.o_lookup_count = lookup_cnt_q;
    assign bus.o_hit_count    = hit_cnt_q;

    assign up_hit     = valid_q[up_idx] & (tag_mem[up_idx] == up_tag);
    assign upd_accept = bus.i_upd_valid & ~busy & ~bus.i_flush_req;

    btb_sat_counter u_sat_counter (
        .hit      (up_hit),
        .is_jump  (bus.i_upd_is_jump),
        .outcome  (bus.i_upd_outcome),
        .ctr      (ctr_mem[up_idx]),
        .ctr_next (ctr_next)
    );

    // Update decision: train on hit, allocate on taken/jump miss, ignore not-taken miss.
    always_comb begin
        wr_en           = 1'b0;
        wr_target_en    = 1'b0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = up_tag;
        wr_entry.target = bus.i_upd_target;
        wr_entry.ctr    = ctr_next;
        if (upd_accept) begin
            if (up_hit) begin
                wr_en        = 1'b1;
                wr_target_en = bus.i_upd_is_jump | (bus.i_upd_outcome == TAKEN);
            end else if (bus.i_upd_is_jump || bus.i_upd_outcome == TAKEN) begin
                wr_en        = 1'b1;
                wr_target_en = 1'b1;
            end
        end
    end

    // Payload write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[up_idx] <= wr_entry.tag;
            ctr_mem[up_idx] <= wr_entry.ctr;
            if (wr_target_en) target_mem[up_idx] <= wr_entry.target;
        end
    end

    // Walk/ready FSM plus valid-bit maintenance.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        valid_d   = valid_q;
        case (state_q)
            BTB_CLEAR: begin
                valid_d[clr_idx_q] = 1'b0;
                if (bus.i_flush_req) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == IW'(ENTRIES - 1)) begin
                    state_d   = BTB_READY;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + IW'(1);
                end
            end
            BTB_READY: begin
                if (bus.i_flush_req) begin
                    state_d   = BTB_CLEAR;
                    clr_idx_d = '0;
                end else if (wr_en) begin
                    valid_d[up_idx] = wr_entry.valid;
                end
            end
            default: begin
                state_d   = BTB_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Saturating statistics; only reset clears them.
    always_comb begin
        lookup_cnt_d = lookup_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (bus.i_lookup_valid && !busy && !(&lookup_cnt_q)) lookup_cnt_d = lookup_cnt_q + STAT_W'(1);
        if (lk_hit && !(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + STAT_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BTB_CLEAR;
            clr_idx_q    <= '0;
            valid_q      <= '0;
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            valid_q      <= valid_d;
            lookup_cnt_q <= lookup_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-stage branch target buffer. Direct-mapped, tagged, with a 2-bit saturating counter per entry.
- Upstream of the decode-stage branch controller: it supplies a predicted next-PC and a direction in the same cycle as the fetch PC.
- Trained by the EX-stage branch result (PC, target, outcome).
- Provides a sequential invalidate walk, run after reset and on flush request, plus hit/lookup statistics counters.

Parameters:
- ENTRIES, 64, number of entries; power of two, at least 2.
- ADDR_W, `ADDR_WIDTH, PC/target width.
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_lookup_valid  in  1  fetch lookup request
- i_lookup_pc  in  ADDR_W  fetch PC
- o_hit  out  1  valid tagged match this cycle
- o_target  out  ADDR_W  stored target; 0 when o_hit=0
- o_prediction  out  BranchOutcome  TAKEN iff o_hit and counter[1]=1
- i_upd_valid  in  1  EX branch/jump resolved
- i_upd_pc  in  ADDR_W  PC of resolved instruction
- i_upd_target  in  ADDR_W  resolved target
- i_upd_outcome  in  BranchOutcome  actual direction
- i_upd_is_jump  in  1  unconditional jump
- i_flush_req  in  1  invalidate all entries
- o_busy  out  1  invalidate walk in progress
- o_lookup_count  out  STAT_W  accepted lookups
- o_hit_count  out  STAT_W  accepted lookups that hit

Behaviour:
- Address split, with IW = log2(ENTRIES):
  - index = pc[IW+1:2]
  - tag = pc[ADDR_W-1:IW+2]
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target, ctr[1:0]. Only the valid bits and the FSM are reset; tag, target and ctr storage is not reset, so it is RAM-friendly.
- Lookup is a combinational read with zero latency:
  - o_hit = i_lookup_valid & ~o_busy & valid[idx] & (tag match).
  - When o_hit=0: o_target=0 and o_prediction=NOT_TAKEN.
- Update is written at posedge when i_upd_valid & ~o_busy:
  - Hit, conditional branch: ctr saturating +1 on TAKEN, -1 on NOT_TAKEN. Target is written only on TAKEN.
  - Hit, jump: ctr=2'b11; target written.
  - Miss, outcome TAKEN or is_jump: allocate (overwrite the index). Write valid=1, the tag and the target. Set ctr=2'b11 for a jump, otherwise 2'b10.
  - Miss, NOT_TAKEN branch: no write.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (no bypass). The update takes effect the next cycle.
- FSM states:
  - CLEAR: clr_idx walks 0..ENTRIES-1, clearing valid[clr_idx] one per cycle.
    - o_busy=1; lookups return miss; updates are dropped; statistics do not count.
    - When clr_idx=ENTRIES-1, go to READY on the next edge.
  - READY: o_busy=0.
- Transitions:
  - rst asserted, at any time: state=CLEAR, clr_idx=0, all valid bits=0, counters=0.
  - After rst deasserts, o_busy stays high for exactly ENTRIES cycles.
  - i_flush_req in READY: CLEAR on the next edge with clr_idx=0. An update presented in the same cycle is dropped.
  - i_flush_req during CLEAR: clr_idx restarts at 0.
- Statistics:
  - o_lookup_count increments on i_lookup_valid & ~o_busy.
  - o_hit_count increments on o_hit.
  - Both saturate at all-ones; they are cleared only by rst, not by flush.
- Reset values:
  - o_busy=1
  - o_hit=0
  - o_target=0
  - o_prediction=NOT_TAKEN
  - o_lookup_count=0
  - o_hit_count=0

Decomposition:
- mips_core_pkg gains:
  - typedef struct BtbEntry {valid, tag, target, ctr}
  - typedef enum BtbState {BTB_CLEAR, BTB_READY}
  - constants BTB_CTR_WEAK_TAKEN=2'b10 and BTB_CTR_STRONG_TAKEN=2'b11.
- It reuses the existing BranchOutcome.
- One sub-module, btb_sat_counter: combinational next-ctr from (hit, is_jump, outcome, ctr). It is unit-testable on its own.

Test Plan:
- Reset, then idle: o_busy=1 for exactly 64 cycles. A lookup of PC 0x0040_0010 during the walk gives o_hit=0 and lookup_count stays 0. After the walk, the same lookup misses and lookup_count=1.
- Update PC 0x0040_0010, target 0x0040_0100, TAKEN, then look up the same PC: o_hit=1, o_target=0x0040_0100, o_prediction=TAKEN (ctr=10). Two NOT_TAKEN updates then give ctr=00 and NOT_TAKEN, with the hit retained.
- Miss-update with NOT_TAKEN at PC 0x0040_0020: no allocation; a later lookup misses. A jump update at the same PC gives ctr=11, and three NOT_TAKEN updates leave ctr=00.
- Aliasing: allocate PC 0x0040_0010, then update TAKEN at PC 0x0040_0110 (same index 4, different tag). The first PC now misses and the second hits with the new target.
- Same-cycle lookup and allocation at the same PC: o_hit=0 that cycle and o_hit=1 the next cycle.
- Flush in READY with a simultaneous update: o_busy rises the next cycle for 64 cycles, the update is lost, and all prior entries miss afterwards. Statistics are preserved. Asserting rst mid-walk restarts the walk from clr_idx=0 and clears the statistics.
